and_gate_bist: RTL and testbench
================================

Name: and_gate_bist

Overview:
- Sequential built-in self-test controller for the 2-input AND gate block.
- Sits on both sides of the gate. It drives the gate inputs `a`/`b` upstream, and it samples the gate output `c` downstream.
- Steps the four input vectors in order 00, 01, 10, 11, waits a settle time, then compares `c` against the expected AND result.
- Reports a per-vector fail mask and a pass flag.

Parameters:
- SETTLE_CYCLES, 2, clock cycles each vector is held before `c` is sampled. Legal range is 1..255.

Ports:
- clk        input   1  system clock, rising-edge active
- rst_n      input   1  synchronous active-low reset
- start      input   1  begin a test run; sampled only in IDLE
- c          input   1  output of the AND gate under test
- a          output  1  AND gate input a
- b          output  1  AND gate input b
- busy       output  1  high while a run is in progress (SETTLE or SAMPLE)
- done       output  1  one-cycle pulse at the end of a run
- pass       output  1  result of the last completed run; 1 means all four vectors matched
- fail_mask  output  4  bit i = 1 if vector i mismatched (i = {a,b} as a 2-bit value)
- vec_idx    output  2  index of the vector currently applied

Behaviour:
- Reset (rst_n == 0 at a rising edge):
  - state = IDLE.
  - a, b, busy, done, pass = 0; fail_mask = 0; vec_idx = 0; settle counter = 0.
  - Reset wins over every other condition, including mid-run; no partial result is retained.
- Vector mapping: a = vec_idx[1], b = vec_idx[0]. The expected value is a & b, evaluated on the registered a/b.
- States: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
- IDLE:
  - a = b = 0.
  - On start == 1: clear fail_mask, set vec_idx = 0, a = b = 0, counter = 0, go to SETTLE.
  - pass holds its previous value until the next start; it is cleared to 0 on start.
- SETTLE:
  - busy = 1; counter increments every cycle.
  - When counter == SETTLE_CYCLES-1, go to SAMPLE. SETTLE therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE:
  - busy = 1; this lasts exactly one cycle.
  - If c != (a & b), set fail_mask[vec_idx].
  - If vec_idx == 3, go to DONE.
  - Otherwise increment vec_idx, update a/b to the new vector, counter = 0, go to SETTLE.
- DONE:
  - busy = 0, done = 1 for exactly one cycle, pass = (final fail_mask == 0).
  - a/b return to 0; next state is IDLE unconditionally.
- Latency:
  - Taking the edge that samples start as edge 0, state is DONE (done = 1) after edge 4*(SETTLE_CYCLES+1).
  - With the default, done = 1 after edge 12.
- Boundary conditions:
  - start while busy or in DONE: ignored; no restart and no effect on the run.
  - start held high continuously: a new run begins on the edge after DONE returns to IDLE.
  - start and rst_n low on the same edge: reset wins.
  - vec_idx does not wrap mid-run. The run terminates after index 3; vec_idx returns to 0 only on the next start or reset.
  - A mismatch bit, once set, stays set until the next start or reset.
  - `c` is sampled only in SAMPLE; its value in every other state is ignored.

Test Plan:
- Correct AND model on `c`, SETTLE_CYCLES=2:
  - start pulse -> a/b sequence 00, 01, 10, 11, each held 3 cycles.
  - done pulse after edge 12; pass = 1, fail_mask = 4'b0000.
  - busy high for 12 cycles.
- OR gate substituted for the AND model -> fail_mask = 4'b0110, pass = 0.
- `c` stuck at 1 -> fail_mask = 4'b0111, pass = 0.
- `c` stuck at 0 -> fail_mask = 4'b1000, pass = 0.
- Timing with SETTLE_CYCLES=1:
  - `c` glitches wrong in the SETTLE cycle but is correct in the SAMPLE cycle -> pass = 1.
  - done after edge 8.
- Control corner cases:
  - start re-pulsed at edge 5 -> ignored; done still after edge 12.
  - rst_n low at edge 7 -> next cycle busy = 0, a = b = 0, fail_mask = 0, pass = 0, state IDLE.
  - A subsequent start completes a normal run.

Source files
------------

// File: rtl/and_gate_bist_if.sv
// Signal bundle between the AND-gate BIST controller and the gate/test harness.
// The slave side is the controller; the master side drives start and the gate output c.
interface and_gate_bist_if;
    logic       start;
    logic       c;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;
    logic [1:0] vec_idx;

    modport master (
        output start, c,
        input  a, b, busy, done, pass, fail_mask, vec_idx
    );

    modport slave (
        input  start, c,
        output a, b, busy, done, pass, fail_mask, vec_idx
    );
endinterface

// File: rtl/and_gate_bist.sv
// BIST controller for a 2-input AND gate: walks vectors 00,01,10,11, lets each settle,
// samples c once per vector and reports a per-vector fail mask plus an overall pass flag.
module and_gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..255
) (
    input  logic           clk,
    input  logic           rst_n,
    and_gate_bist_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] vec_q, vec_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [3:0] mask_q, mask_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        a_d     = a_q;
        b_d     = b_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (bus.start) begin
                    mask_d  = 4'b0000;
                    vec_d   = 2'd0;
                    cnt_d   = 8'd0;
                    pass_d  = 1'b0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // c is only trusted here, after the vector has been held for the full settle time
                if (bus.c != (a_q & b_q)) begin
                    mask_d[vec_q] = 1'b1;
                end
                if (vec_q == 2'd3) begin
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    pass_d  = (mask_d == 4'b0000);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    a_d     = vec_d[1];
                    b_d     = vec_d[0];
                    cnt_d   = 8'd0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered copies of the state being entered
        busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            vec_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.fail_mask = mask_q;
    assign bus.vec_idx   = vec_q;

endmodule

// File: tb/tb_and_gate_bist.sv
// Bench for and_gate_bist: two instances (SETTLE_CYCLES 2 and 1) driven through the interface,
// with gate models on c and a queue of expected run results checked at each done pulse.
module tb_and_gate_bist;

    localparam int M_AND = 0;
    localparam int M_OR  = 1;
    localparam int M_ST1 = 2;
    localparam int M_ST0 = 3;

    typedef struct {
        logic [3:0] mask;
        logic       pass;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   mode2;
    logic glitch1;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    and_gate_bist_if bus2 ();
    and_gate_bist_if bus1 ();

    and_gate_bist #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    and_gate_bist #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    function automatic logic model_c(input int m, input logic a, input logic b);
        case (m)
            M_OR:    return a | b;
            M_ST1:   return 1'b1;
            M_ST0:   return 1'b0;
            default: return a & b;
        endcase
    endfunction

    always_comb bus2.c = model_c(mode2, bus2.a, bus2.b);
    always_comb bus1.c = glitch1 ? ~(bus1.a & bus1.b) : (bus1.a & bus1.b);

    function automatic void push_run(input int m, input int lat);
        exp_t e;
        logic [1:0] vv;
        e.mask = 4'b0000;
        for (int v = 0; v < 4; v++) begin
            vv = 2'(v);
            if (model_c(m, vv[1], vv[0]) !== (vv[1] & vv[0])) e.mask[v] = 1'b1;
        end
        e.pass = (e.mask == 4'b0000);
        e.lat  = lat;
        sbq.push_back(e);
    endfunction

    // One run on the SETTLE_CYCLES=2 instance; optionally re-pulses start so it is sampled at edge restart_k
    task automatic run_s2(input int m, input int restart_k, input string nm);
        exp_t e;
        int k;
        bit seen;
        logic [1:0] v;
        mode2 = m;
        push_run(m, 12);
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (bus2.done) begin
                seen = 1'b1;
            end else begin
                if (k < 12) begin
                    v = 2'(k / 3);
                    checks++;
                    if ({bus2.busy, bus2.vec_idx, bus2.a, bus2.b} !== {1'b1, v, v}) begin
                        errors++;
                        $display("FAIL %s seq edge %0d: busy/vec/a/b got %b required %b", nm, k,
                                 {bus2.busy, bus2.vec_idx, bus2.a, bus2.b}, {1'b1, v, v});
                    end
                end
                bus2.start = (k == restart_k - 1);
                @(posedge clk); #1;
                k++;
            end
        end
        bus2.start = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (!seen || k != e.lat) begin
            errors++;
            $display("FAIL %s latency: done seen=%0b at edge %0d, required edge %0d", nm, seen, k, e.lat);
        end
        checks++;
        if ({bus2.fail_mask, bus2.pass} !== {e.mask, e.pass}) begin
            errors++;
            $display("FAIL %s result: mask/pass got %b/%b required %b/%b", nm,
                     bus2.fail_mask, bus2.pass, e.mask, e.pass);
        end
        checks++;
        if ({bus2.busy, bus2.a, bus2.b} !== 3'b000) begin
            errors++;
            $display("FAIL %s done state: busy/a/b got %b required 000", nm, {bus2.busy, bus2.a, bus2.b});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus2.done, bus2.busy, bus2.pass} !== {2'b00, e.pass}) begin
            errors++;
            $display("FAIL %s after done: done/busy/pass got %b required %b", nm,
                     {bus2.done, bus2.busy, bus2.pass}, {2'b00, e.pass});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus2.start = 1'b1;
        bus1.start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.fail_mask, bus2.vec_idx} !== 11'b0) begin
            errors++;
            $display("FAIL reset dut2: outputs got %b required 0",
                     {bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.fail_mask, bus2.vec_idx});
        end
        checks++;
        if ({bus1.busy, bus1.done, bus1.pass, bus1.a, bus1.b, bus1.fail_mask, bus1.vec_idx} !== 11'b0) begin
            errors++;
            $display("FAIL reset dut1: outputs got %b required 0",
                     {bus1.busy, bus1.done, bus1.pass, bus1.a, bus1.b, bus1.fail_mask, bus1.vec_idx});
        end
        bus2.start = 1'b0;
        bus1.start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({bus2.busy, bus1.busy} !== 2'b00) begin
            errors++;
            $display("FAIL reset release: busy got %b required 00", {bus2.busy, bus1.busy});
        end
    endtask

    task automatic test_and_model();
        run_s2(M_AND, -1, "and_model");
    endtask

    task automatic test_or_model();
        run_s2(M_OR, -1, "or_model");
    endtask

    task automatic test_stuck1();
        run_s2(M_ST1, -1, "stuck1");
    endtask

    task automatic test_stuck0();
        run_s2(M_ST0, -1, "stuck0");
    endtask

    task automatic test_restart_ignored();
        run_s2(M_AND, 5, "restart_ignored");
    endtask

    // c is wrong during every SETTLE cycle and right during every SAMPLE cycle
    task automatic test_settle1_glitch();
        exp_t e;
        int k;
        bit seen;
        logic [1:0] v;
        e.mask = 4'b0000;
        e.pass = 1'b1;
        e.lat  = 8;
        sbq.push_back(e);
        glitch1 = 1'b1;
        bus1.start = 1'b1;
        @(posedge clk); #1;
        bus1.start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 30) begin
            if (bus1.done) begin
                seen = 1'b1;
            end else begin
                glitch1 = (k % 2 == 0);
                if (k < 8) begin
                    v = 2'(k / 2);
                    checks++;
                    if ({bus1.busy, bus1.a, bus1.b} !== {1'b1, v}) begin
                        errors++;
                        $display("FAIL glitch seq edge %0d: busy/a/b got %b required %b", k,
                                 {bus1.busy, bus1.a, bus1.b}, {1'b1, v});
                    end
                end
                @(posedge clk); #1;
                k++;
            end
        end
        glitch1 = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (!seen || k != e.lat) begin
            errors++;
            $display("FAIL glitch latency: done seen=%0b at edge %0d, required edge %0d", seen, k, e.lat);
        end
        checks++;
        if ({bus1.fail_mask, bus1.pass} !== {e.mask, e.pass}) begin
            errors++;
            $display("FAIL glitch result: mask/pass got %b/%b required %b/%b",
                     bus1.fail_mask, bus1.pass, e.mask, e.pass);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        mode2 = M_OR;
        bus2.start = 1'b1;
        @(posedge clk); #1;
        bus2.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if ({bus2.fail_mask, bus2.vec_idx, bus2.busy} !== {4'b0010, 2'd2, 1'b1}) begin
            errors++;
            $display("FAIL midrun edge 6: mask/vec/busy got %b required %b",
                     {bus2.fail_mask, bus2.vec_idx, bus2.busy}, {4'b0010, 2'd2, 1'b1});
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.fail_mask, bus2.vec_idx} !== 11'b0) begin
            errors++;
            $display("FAIL midrun reset: outputs got %b required 0",
                     {bus2.busy, bus2.done, bus2.pass, bus2.a, bus2.b, bus2.fail_mask, bus2.vec_idx});
        end
        @(posedge clk); #1;
        checks++;
        if ({bus2.busy, bus2.done} !== 2'b00) begin
            errors++;
            $display("FAIL midrun idle: busy/done got %b required 00", {bus2.busy, bus2.done});
        end
        mode2 = M_AND;
    endtask

    task automatic test_after_reset();
        run_s2(M_AND, -1, "after_reset");
    endtask

    // start held high: second run begins on the edge after DONE returns to IDLE
    task automatic test_back_to_back();
        exp_t e;
        int k;
        int n;
        mode2 = M_ST0;
        push_run(M_ST0, 12);
        push_run(M_ST0, 26);
        bus2.start = 1'b1;
        @(posedge clk); #1;
        k = 0;
        n = 0;
        while (n < 2 && k < 40) begin
            if (bus2.done) begin
                e = sbq.pop_front();
                n++;
                checks++;
                if (k != e.lat || {bus2.fail_mask, bus2.pass} !== {e.mask, e.pass}) begin
                    errors++;
                    $display("FAIL b2b run %0d: edge %0d mask/pass %b/%b, required edge %0d mask/pass %b/%b",
                             n, k, bus2.fail_mask, bus2.pass, e.lat, e.mask, e.pass);
                end
                if (n == 2) bus2.start = 1'b0;
            end
            if (k == 13) begin
                checks++;
                if ({bus2.busy, bus2.done} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b idle edge 13: busy/done got %b required 00", {bus2.busy, bus2.done});
                end
            end
            if (k == 14) begin
                checks++;
                if ({bus2.busy, bus2.vec_idx, bus2.fail_mask} !== {1'b1, 2'd0, 4'b0000}) begin
                    errors++;
                    $display("FAIL b2b restart edge 14: busy/vec/mask got %b required %b",
                             {bus2.busy, bus2.vec_idx, bus2.fail_mask}, {1'b1, 2'd0, 4'b0000});
                end
            end
            @(posedge clk); #1;
            k++;
        end
        bus2.start = 1'b0;
        if (n < 2) begin
            checks++;
            errors++;
            $display("FAIL b2b timeout: %0d done pulses seen, required 2", n);
            while (sbq.size() > 0) void'(sbq.pop_front());
        end
        repeat (2) @(posedge clk);
        #1;
        mode2 = M_AND;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus2.start = 1'b0;
        bus1.start = 1'b0;
        mode2      = M_AND;
        glitch1    = 1'b0;
        test_reset();
        test_and_model();
        test_or_model();
        test_stuck1();
        test_stuck0();
        test_settle1_glitch();
        test_restart_ignored();
        test_reset_midrun();
        test_after_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
